// File: rtl/cnt_seq.sv
// cnt_seq: sequencer that drives an external up-counter through one count
// sequence (IDLE -> LOAD -> RUN) from a captured preload to a captured term.
// Optional build macro: CNT_SEQ_AUTORELOAD_EN -- on a terminal match the
// sequencer reloads the counter and keeps cycling until stop is asserted.
module cnt_seq #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] preload,
   input  logic [WIDTH-1:0] term,
   input  logic [WIDTH-1:0] cnt_out,
   output logic             load,
   output logic             enab,
   output logic [WIDTH-1:0] cnt_in,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] term_q;
   logic             match;

   // Counter has reached the captured terminal value
   assign match = (cnt_out == term_q);

   // Sequencer state, captured operands and registered busy/done flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         term_q <= '0;
         cnt_in <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state  <= LOAD;
                  cnt_in <= preload;
                  term_q <= term;
                  busy   <= 1'b1;
               end
            end
            LOAD: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               // stop takes priority over a simultaneous match: abort, no done
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (match) begin
                  done <= 1'b1;
`ifdef CNT_SEQ_AUTORELOAD_EN
                  state <= LOAD;
`else
                  state <= IDLE;
                  busy  <= 1'b0;
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Counter control decode; enab in RUN follows cnt_out/stop without a cycle of delay
   always_comb begin
      load = 1'b0;
      enab = 1'b0;
      case (state)
         LOAD: begin
            load = 1'b1;
            enab = 1'b1;
         end
         RUN: begin
            enab = !match && !stop;
         end
         default: begin
            load = 1'b0;
            enab = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cnt_seq.sv
// tb_cnt_seq: cnt_seq driving a 5-bit loadable up-counter that shares its reset.
// Per-cycle vector tables plus hand-written reset sequences.
// Extra autoreload rows are used when CNT_SEQ_AUTORELOAD_EN is defined.
module tb_cnt_seq;

   localparam int unsigned W = 5;

   logic         clk;
   logic         rst;
   logic         start;
   logic         stop;
   logic [W-1:0] preload;
   logic [W-1:0] term;
   logic [W-1:0] cnt_out;
   logic         load;
   logic         enab;
   logic [W-1:0] cnt_in;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;
   int row   = 0;

   typedef struct {
      logic         start;
      logic         stop;
      logic [W-1:0] pre;
      logic [W-1:0] term;
      logic         e_load;
      logic         e_enab;
      logic         e_busy;
      logic         e_done;
      logic [W-1:0] e_cnt;
      logic [W-1:0] e_cin;
   } vec_t;

   vec_t vecs[$];

   cnt_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .preload (preload),
      .term    (term),
      .cnt_out (cnt_out),
      .load    (load),
      .enab    (enab),
      .cnt_in  (cnt_in),
      .busy    (busy),
      .done    (done)
   );

   // Downstream loadable up-counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      cnt_out <= '0;
      else if (load) cnt_out <= cnt_in;
      else if (enab) cnt_out <= cnt_out + 5'd1;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d t=%0t actual=%h required=%h", name, row, $time, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic sp, input logic [W-1:0] pr, input logic [W-1:0] tm,
                      input logic el, input logic ee, input logic eb, input logic ed,
                      input logic [W-1:0] ec, input logic [W-1:0] eci);
      vec_t v;
      v.start = st;  v.stop = sp;  v.pre = pr;  v.term = tm;
      v.e_load = el; v.e_enab = ee; v.e_busy = eb; v.e_done = ed;
      v.e_cnt = ec;  v.e_cin = eci;
      vecs.push_back(v);
   endtask

   // Each row: drive inputs after the falling edge, check that cycle's outputs
   task automatic run_table();
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         start   = vecs[i].start;
         stop    = vecs[i].stop;
         preload = vecs[i].pre;
         term    = vecs[i].term;
         #1;
         chk("load",    5'(load), 5'(vecs[i].e_load));
         chk("enab",    5'(enab), 5'(vecs[i].e_enab));
         chk("busy",    5'(busy), 5'(vecs[i].e_busy));
         chk("done",    5'(done), 5'(vecs[i].e_done));
         chk("cnt_out", cnt_out,  vecs[i].e_cnt);
         chk("cnt_in",  cnt_in,   vecs[i].e_cin);
         row++;
      end
      vecs.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_load"},   5'(load), 5'd0);
      chk({tag, "_enab"},   5'(enab), 5'd0);
      chk({tag, "_busy"},   5'(busy), 5'd0);
      chk({tag, "_done"},   5'(done), 5'd0);
      chk({tag, "_cnt_in"}, cnt_in,   5'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; preload = '0; term = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("por");
      chk("por_cnt", cnt_out, 5'd0);
      @(negedge clk);
      rst = 1'b1;

      // Basic 03 -> 07: done 6 edges after the accepting edge
      add(1,0,5'h03,5'h07, 0,0,0,0, 5'h00,5'h00);
      add(0,0,5'h03,5'h07, 1,1,1,0, 5'h00,5'h03);
      add(0,0,5'h03,5'h07, 0,1,1,0, 5'h03,5'h03);
      add(0,0,5'h03,5'h07, 0,1,1,0, 5'h04,5'h03);
      add(0,0,5'h03,5'h07, 0,1,1,0, 5'h05,5'h03);
      add(0,0,5'h03,5'h07, 0,1,1,0, 5'h06,5'h03);
      add(0,0,5'h03,5'h07, 0,0,1,0, 5'h07,5'h03);
      add(0,0,5'h03,5'h07, 0,0,0,1, 5'h07,5'h03);
      add(0,0,5'h03,5'h07, 0,0,0,0, 5'h07,5'h03);
      // Wrap 1E -> 01, with an ignored start mid-sequence
      add(1,0,5'h1E,5'h01, 0,0,0,0, 5'h07,5'h03);
      add(0,0,5'h1E,5'h01, 1,1,1,0, 5'h07,5'h1E);
      add(0,0,5'h1E,5'h01, 0,1,1,0, 5'h1E,5'h1E);
      add(1,0,5'h00,5'h00, 0,1,1,0, 5'h1F,5'h1E);
      add(0,0,5'h1E,5'h01, 0,1,1,0, 5'h00,5'h1E);
      add(0,0,5'h1E,5'h01, 0,0,1,0, 5'h01,5'h1E);
      add(0,0,5'h1E,5'h01, 0,0,0,1, 5'h01,5'h1E);
      add(0,0,5'h1E,5'h01, 0,0,0,0, 5'h01,5'h1E);
      // Equal 0A == 0A: no counting, done 2 edges after start
      add(1,0,5'h0A,5'h0A, 0,0,0,0, 5'h01,5'h1E);
      add(0,0,5'h0A,5'h0A, 1,1,1,0, 5'h01,5'h0A);
      add(0,0,5'h0A,5'h0A, 0,0,1,0, 5'h0A,5'h0A);
      add(0,0,5'h0A,5'h0A, 0,0,0,1, 5'h0A,5'h0A);
      add(0,0,5'h0A,5'h0A, 0,0,0,0, 5'h0A,5'h0A);
      // Abort at 05, ignored start mid-run, then start blocked by stop in IDLE
      add(1,0,5'h02,5'h09, 0,0,0,0, 5'h0A,5'h0A);
      add(0,0,5'h02,5'h09, 1,1,1,0, 5'h0A,5'h02);
      add(0,0,5'h02,5'h09, 0,1,1,0, 5'h02,5'h02);
      add(1,0,5'h1F,5'h1F, 0,1,1,0, 5'h03,5'h02);
      add(0,0,5'h02,5'h09, 0,1,1,0, 5'h04,5'h02);
      add(0,1,5'h02,5'h09, 0,0,1,0, 5'h05,5'h02);
      add(0,0,5'h02,5'h09, 0,0,0,0, 5'h05,5'h02);
      add(0,0,5'h02,5'h09, 0,0,0,0, 5'h05,5'h02);
      add(1,1,5'h07,5'h07, 0,0,0,0, 5'h05,5'h02);
      add(0,0,5'h07,5'h07, 0,0,0,0, 5'h05,5'h02);
      // Into RUN, then asynchronous reset
      add(1,0,5'h04,5'h08, 0,0,0,0, 5'h05,5'h02);
      add(0,0,5'h04,5'h08, 1,1,1,0, 5'h05,5'h04);
      add(0,0,5'h04,5'h08, 0,1,1,0, 5'h04,5'h04);
      run_table();

      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_outputs("rst_run");
      chk("rst_run_cnt", cnt_out, 5'd0);
      @(negedge clk);
      rst = 1'b1;

      // Restart after reset, then reset while done is high
      add(1,0,5'h0A,5'h0A, 0,0,0,0, 5'h00,5'h00);
      add(0,0,5'h0A,5'h0A, 1,1,1,0, 5'h00,5'h0A);
      add(0,0,5'h0A,5'h0A, 0,0,1,0, 5'h0A,5'h0A);
      run_table();

      @(negedge clk);
      chk("pre_rst_done", 5'(done), 5'd1);
      rst = 1'b0;
      #1;
      chk_reset_outputs("rst_done");
      @(negedge clk);
      rst = 1'b1;

      // 10 -> 12: single-shot by default, periodic reload when enabled
      add(1,0,5'h10,5'h12, 0,0,0,0, 5'h00,5'h00);
      add(0,0,5'h10,5'h12, 1,1,1,0, 5'h00,5'h10);
      add(0,0,5'h10,5'h12, 0,1,1,0, 5'h10,5'h10);
      add(0,0,5'h10,5'h12, 0,1,1,0, 5'h11,5'h10);
      add(0,0,5'h10,5'h12, 0,0,1,0, 5'h12,5'h10);
`ifdef CNT_SEQ_AUTORELOAD_EN
      add(0,0,5'h10,5'h12, 1,1,1,1, 5'h12,5'h10);
      add(0,0,5'h10,5'h12, 0,1,1,0, 5'h10,5'h10);
      add(0,0,5'h10,5'h12, 0,1,1,0, 5'h11,5'h10);
      add(0,0,5'h10,5'h12, 0,0,1,0, 5'h12,5'h10);
      add(0,0,5'h10,5'h12, 1,1,1,1, 5'h12,5'h10);
      add(0,1,5'h10,5'h12, 0,0,1,0, 5'h10,5'h10);
      add(0,0,5'h10,5'h12, 0,0,0,0, 5'h10,5'h10);
      add(0,0,5'h10,5'h12, 0,0,0,0, 5'h10,5'h10);
`else
      add(0,0,5'h10,5'h12, 0,0,0,1, 5'h12,5'h10);
      add(0,0,5'h10,5'h12, 0,0,0,0, 5'h12,5'h10);
      add(0,0,5'h10,5'h12, 0,0,0,0, 5'h12,5'h10);
`endif
      run_table();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
